// File: rtl/pkt_fifo_arbiter.sv
// rtl/pkt_fifo_arbiter.sv - packet-atomic round-robin arbiter feeding one output FIFO
// Optional watchdog on a stalled packet: define PKT_ARB_TIMEOUT_EN.
module pkt_fifo_arbiter #(
  parameter int NREQ        = 2,
  parameter int DW          = 16,
  parameter int PKT_MAX     = 64,
  parameter int FIFO_DEPTH  = 1024,
  parameter int AW          = 11,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    src_wr_i,
  input  logic [NREQ*DW-1:0] src_data_i,
  input  logic [NREQ-1:0]    done_i,
  output logic [NREQ-1:0]    grant_o,
  input  logic [AW-1:0]      fifo_wcnt_i,
  input  logic               fifo_full_i,
  output logic               fifo_wr_o,
  output logic [DW-1:0]      fifo_data_o,
  output logic               busy_o,
  output logic [15:0]        pkt_cnt_o,
  output logic [1:0]         err_o,
  input  logic               err_clr_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(PKT_MAX + 1);
  localparam logic [AW:0] DEPTH_X = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] NEED_X  = (AW+1)'(PKT_MAX + 1);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_wcnt;
  logic [7:0]    r_seq [NREQ];
  logic [1:0]    r_err;

  logic [AW:0]   w_cnt_x;
  logic          w_elig;
  logic          w_any;
  logic [IW-1:0] w_pick;
  logic [IW-1:0] w_j;
  logic          w_wr;
  logic          w_done;
  logic [DW-1:0] w_data;
  logic          w_drop;
  logic [DW-1:0] w_hdr;

  // Guard the subtraction so an out-of-range fill count can never wrap into "eligible".
  assign w_cnt_x = {1'b0, fifo_wcnt_i};
  assign w_elig  = (w_cnt_x <= DEPTH_X) && ((DEPTH_X - w_cnt_x) >= NEED_X);

  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_j    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_j = IW'((int'(r_ptr) + i) % NREQ);
      if (!w_any && req_i[w_j]) begin
        w_any  = 1'b1;
        w_pick = w_j;
      end
    end
  end

  always_comb begin
    w_wr   = 1'b0;
    w_done = 1'b0;
    w_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_idx == IW'(k)) begin
        w_wr   = src_wr_i[k];
        w_done = done_i[k];
        w_data = src_data_i[k*DW +: DW];
      end
    end
  end

  assign w_drop = w_wr && ((r_wcnt == CW'(PKT_MAX)) || fifo_full_i);
  assign w_hdr  = DW'({4'hA, 4'(w_pick), r_seq[w_pick]});
  assign err_o  = r_err;

`ifdef PKT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tmo;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= IW'(NREQ - 1);
      r_idx       <= '0;
      r_wcnt      <= '0;
      r_err       <= '0;
      grant_o     <= '0;
      fifo_wr_o   <= 1'b0;
      fifo_data_o <= '0;
      busy_o      <= 1'b0;
      pkt_cnt_o   <= '0;
      for (int k = 0; k < NREQ; k++) r_seq[k] <= '0;
`ifdef PKT_ARB_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else begin
      // Clear first so a same-cycle set (assigned later) takes precedence.
      if (err_clr_i) r_err <= '0;
      case (r_state)
        IDLE: begin
          fifo_wr_o <= 1'b0;
          if (w_any && w_elig) begin
            grant_o     <= NREQ'(1) << w_pick;
            r_ptr       <= w_pick;
            r_idx       <= w_pick;
            fifo_wr_o   <= 1'b1;
            fifo_data_o <= w_hdr;
            r_wcnt      <= '0;
            busy_o      <= 1'b1;
            r_state     <= XFER;
`ifdef PKT_ARB_TIMEOUT_EN
            r_tmo       <= '0;
`endif
          end
        end
        XFER: begin
          fifo_wr_o   <= w_wr && !w_drop;
          fifo_data_o <= w_data;
          if (w_wr && !w_drop) r_wcnt <= r_wcnt + CW'(1);
          if (w_drop) r_err[0] <= 1'b1;
          if (w_done) begin
            grant_o        <= '0;
            r_seq[r_idx]   <= r_seq[r_idx] + 8'd1;
            pkt_cnt_o      <= pkt_cnt_o + 16'd1;
            r_state        <= GAP;
          end
`ifdef PKT_ARB_TIMEOUT_EN
          else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
            grant_o  <= '0;
            r_err[1] <= 1'b1;
            r_state  <= GAP;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
`endif
        end
        GAP: begin
          fifo_wr_o <= 1'b0;
          busy_o    <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_fifo_arbiter.sv
// tb/tb_pkt_fifo_arbiter.sv - scoreboard bench for pkt_fifo_arbiter
// Build with PKT_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_pkt_fifo_arbiter;
  localparam int NREQ = 2;
  localparam int DW   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_i;
  logic [NREQ-1:0]   src_wr_i;
  logic [NREQ*DW-1:0] src_data_i;
  logic [NREQ-1:0]   done_i;
  logic [NREQ-1:0]   grant_o;
  logic [10:0]       fifo_wcnt_i;
  logic              fifo_full_i;
  logic              fifo_wr_o;
  logic [DW-1:0]     fifo_data_o;
  logic              busy_o;
  logic [15:0]       pkt_cnt_o;
  logic [1:0]        err_o;
  logic              err_clr_i;

  logic [15:0] exp_q[$];
  logic [7:0]  exp_seq [NREQ];
  int          exp_pkt;
  int          n_vec = 0;
  int          n_err = 0;
  int          c;
  logic [15:0] hdr;

  pkt_fifo_arbiter #(
    .NREQ(NREQ), .DW(DW), .PKT_MAX(64), .FIFO_DEPTH(1024), .AW(11), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .src_wr_i(src_wr_i), .src_data_i(src_data_i),
    .done_i(done_i), .grant_o(grant_o), .fifo_wcnt_i(fifo_wcnt_i), .fifo_full_i(fifo_full_i),
    .fifo_wr_o(fifo_wr_o), .fifo_data_o(fifo_data_o), .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o),
    .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (!rst && fifo_wr_o) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL fifo_write: got unexpected write %h, required no write", fifo_data_o);
      end else begin
        e = exp_q.pop_front();
        if (fifo_data_o !== e) begin
          n_err++;
          $display("FAIL fifo_data: got %h, required %h", fifo_data_o, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_i = '0; src_wr_i = '0; src_data_i = '0; done_i = '0;
    fifo_wcnt_i = '0; fifo_full_i = 1'b0; err_clr_i = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NREQ; k++) exp_seq[k] = 8'd0;
    exp_pkt = 0;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic req_grant(input int src, output int cyc, output logic [15:0] h);
    req_i[src] = 1'b1;
    exp_q.push_back({4'hA, 4'(src), exp_seq[src]});
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!grant_o[src] && cyc < 200);
    check("grant", {30'd0, grant_o}, 32'(1 << src));
    check("hdr_wr", {31'd0, fifo_wr_o}, 32'd1);
    h = fifo_data_o;
  endtask

  task automatic payload(input int src, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      src_wr_i[src] = 1'b1;
      src_data_i[src*DW +: DW] = base + 16'(i);
      if (i < 64) exp_q.push_back(base + 16'(i));
      @(posedge clk); #1;
    end
    src_wr_i[src] = 1'b0;
  endtask

  task automatic finish_pkt(input int src, input bit hold);
    done_i[src] = 1'b1;
    @(posedge clk); #1;
    done_i[src] = 1'b0;
    if (!hold) req_i[src] = 1'b0;
    exp_seq[src]++;
    exp_pkt++;
    check("grant_after_done", {30'd0, grant_o}, 32'd0);
    check("pkt_cnt", {16'd0, pkt_cnt_o}, 32'(exp_pkt));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of run, required completion");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_grant", {30'd0, grant_o}, 32'd0);
    check("rst_wr", {31'd0, fifo_wr_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_pkt_cnt", {16'd0, pkt_cnt_o}, 32'd0);
    check("rst_err", {30'd0, err_o}, 32'd0);

    // Full-size packet from source 0.
    req_grant(0, c, hdr);
    check("grant_latency", 32'(c), 32'd1);
    check("hdr_t1", {16'd0, hdr}, 32'h0000A000);
    check("busy_xfer", {31'd0, busy_o}, 32'd1);
    payload(0, 64, 16'h0000);
    finish_pkt(0, 1'b0);
    check("pkt_cnt_t1", {16'd0, pkt_cnt_o}, 32'd1);
    cycles(3);
    check("q_drain_t1", 32'(exp_q.size()), 32'd0);

    // Two continuous requesters alternate.
    do_reset();
    req_i = 2'b11;
    req_grant(0, c, hdr); check("hdr_rr0", {16'd0, hdr}, 32'h0000A000);
    payload(0, 4, 16'h1000); finish_pkt(0, 1'b1);
    req_grant(1, c, hdr); check("hdr_rr1", {16'd0, hdr}, 32'h0000A100);
    payload(1, 4, 16'h1100); finish_pkt(1, 1'b1);
    req_grant(0, c, hdr); check("hdr_rr2", {16'd0, hdr}, 32'h0000A001);
    payload(0, 4, 16'h1200); finish_pkt(0, 1'b0);
    req_grant(1, c, hdr); check("hdr_rr3", {16'd0, hdr}, 32'h0000A101);
    payload(1, 4, 16'h1300); finish_pkt(1, 1'b0);
    cycles(3);

    // Space check: 64 free words is one short of a header plus a full payload.
    fifo_wcnt_i = 11'd960;
    req_i[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      check("no_grant_full", {30'd0, grant_o}, 32'd0);
    end
    exp_q.push_back({4'hA, 4'd0, exp_seq[0]});
    fifo_wcnt_i = 11'd959;
    cycles(1);
    check("grant_959", {30'd0, grant_o}, 32'd1);
    check("hdr_959", {16'd0, fifo_data_o}, 32'h0000A002);
    payload(0, 3, 16'h2000);
    finish_pkt(0, 1'b0);
    fifo_wcnt_i = '0;
    cycles(2);
    check("err_before_ovr", {30'd0, err_o}, 32'd0);

    // Overlong packet: words beyond 64 dropped and flagged.
    req_grant(1, c, hdr);
    payload(1, 70, 16'h3000);
    finish_pkt(1, 1'b0);
    cycles(2);
    check("err_ovr", {30'd0, err_o}, 32'd1);
    err_clr_i = 1'b1;
    cycles(1);
    err_clr_i = 1'b0;
    check("err_clr", {30'd0, err_o}, 32'd0);
    check("q_drain_t4", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a packet.
    req_grant(0, c, hdr);
    payload(0, 10, 16'h4000);
    @(negedge clk); #1;
    rst = 1'b1;
    req_i = '0;
    #1;
    check("rst_mid_grant", {30'd0, grant_o}, 32'd0);
    check("rst_mid_wr", {31'd0, fifo_wr_o}, 32'd0);
    check("rst_mid_pkt", {16'd0, pkt_cnt_o}, 32'd0);
    check("q_drain_t5", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < NREQ; k++) exp_seq[k] = 8'd0;
    exp_pkt = 0;
    cycles(2);
    rst = 1'b0;
    req_grant(0, c, hdr);
    check("hdr_after_rst", {16'd0, hdr}, 32'h0000A000);
    payload(0, 2, 16'h5000);
    finish_pkt(0, 1'b0);
    cycles(3);

`ifdef PKT_ARB_TIMEOUT_EN
    // Watchdog: source never signals done.
    req_grant(1, c, hdr);
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (grant_o[1] && c < 100);
    req_i = '0;
    check("tmo_cycles", 32'(c), 32'd16);
    check("tmo_err", {31'd0, err_o[1]}, 32'd1);
    check("tmo_pkt_cnt", {16'd0, pkt_cnt_o}, 32'(exp_pkt));
    cycles(3);
`endif

    check("q_final", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pkt_fifo_arbiter.md
Name: pkt_fifo_arbiter

Overview:
Packet-atomic round-robin arbiter that shares one 16-bit output FIFO among NREQ packet sources (spike packetizer, decoder-output packetizer, …).
- Grants a source only when the FIFO has room for a full packet.
- Inserts one header word per packet.
- Drives each source's fifo_ready-style grant line and multiplexes its write strobe and data into the FIFO.
- Sits between the per-bin packetizers and the USB/transmit FIFO.

Parameters:
- NREQ, 2: number of requesters (2..16)
- DW, 16: data word width
- PKT_MAX, 64: maximum payload words per packet
- FIFO_DEPTH, 1024: output FIFO depth in words
- AW, 11: width of the FIFO fill-count input (holds 0..FIFO_DEPTH)
- TIMEOUT_CYC, 4096: watchdog limit in cycles (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_i  in  NREQ  per-source packet request, level
- src_wr_i  in  NREQ  per-source write strobe
- src_data_i  in  NREQ*DW  per-source data; source k occupies bits [k*DW +: DW]
- done_i  in  NREQ  per-source end-of-packet pulse (one cycle)
- grant_o  out  NREQ  one-hot grant; the granted source may write while its bit is high
- fifo_wcnt_i  in  AW  output FIFO fill count
- fifo_full_i  in  1  output FIFO full
- fifo_wr_o  out  1  output FIFO write enable, registered
- fifo_data_o  out  DW  output FIFO write data, registered
- busy_o  out  1  high in XFER or GAP
- pkt_cnt_o  out  16  completed-packet count, wraps at 65535 -> 0
- err_o  out  2  sticky flags: [0] overrun/drop, [1] timeout
- err_clr_i  in  1  clears err_o

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset:
  - state = IDLE; grant_o = 0; fifo_wr_o = 0; fifo_data_o = 0; busy_o = 0.
  - pkt_cnt_o = 0; err_o = 0; round-robin pointer = NREQ-1 (source 0 has first priority).
  - All per-source 8-bit sequence counters = 0.
  - Reset asserted mid-packet aborts the transfer with no further FIFO writes.
- Space check: eligible = (FIFO_DEPTH - fifo_wcnt_i) >= PKT_MAX+1. Compute in AW+1 bits; no underflow.
- IDLE state:
  - If any req_i bit is set and eligible is true: pick the first set bit searching from pointer+1 with wrap.
  - On that same edge: grant_o <= one-hot(k); pointer <= k; fifo_wr_o <= 1; fifo_data_o <= header; word count <= 0; state -> XFER.
  - Header = {4'hA, k[3:0], seq[k][7:0]} for DW=16.
  - If no request is set or eligible is false: remain in IDLE with fifo_wr_o <= 0.
- XFER state:
  - fifo_wr_o <= src_wr_i[k]; fifo_data_o <= src_data_i[k]. Latency is 1 cycle.
  - A write is dropped (fifo_wr_o <= 0, err_o[0] set) when the word count already equals PKT_MAX, or when fifo_full_i is high.
  - Word count increments only on accepted writes.
  - Writes arriving in the same cycle as done_i[k] are accepted, subject to the same drop rules.
  - done_i[k] -> grant_o <= 0; seq[k] += 1 (wraps 255 -> 0); pkt_cnt_o += 1; state -> GAP.
  - src_wr_i, done_i and req_i from ungranted sources are ignored. req_i[k] falling mid-XFER has no effect.
- GAP state:
  - Lasts one cycle with fifo_wr_o <= 0, then state -> IDLE.
  - Guarantees at least 2 cycles between a source's done and its next grant.
  - The next arbitration starts at pointer+1, so a continuously requesting source yields to other requesters.
- err_o:
  - Flags set on the event edge and hold until err_clr_i.
  - If err_clr_i and a set event occur in the same cycle, set wins.

Optional Feature:
PKT_ARB_TIMEOUT_EN
- Defined: a cycle counter runs in XFER and resets at each grant.
  - On reaching TIMEOUT_CYC without done_i[k]: grant_o <= 0; err_o[1] <= 1; state -> GAP.
  - In that case pkt_cnt_o and seq[k] are not incremented.
- Undefined: no watchdog; XFER waits indefinitely for done_i; err_o[1] is tied 0.

Test Plan:
1. Reset, fifo_wcnt_i = 0, req_i = 2'b01, source 0 writes 64 words 0x0000..0x003F, then done pulse.
   -> grant_o = 01 one cycle after request; FIFO receives 0xA000 then 0x0000..0x003F (65 writes); pkt_cnt_o = 1.
2. req_i = 2'b11 held, each source sends 4 words per packet.
   -> grants alternate 01, 10, 01, 10; headers 0xA000, 0xA100, 0xA001, 0xA101.
3. fifo_wcnt_i = 960 (free space 64 < 65) with req_i = 01.
   -> no grant and no writes; drop fifo_wcnt_i to 959 -> grant on the next edge.
4. Granted source writes 70 words.
   -> exactly 64 payload words written; err_o = 2'b01; err_clr_i pulse -> err_o = 0.
5. Assert rst during XFER at word 10.
   -> grant_o, fifo_wr_o and pkt_cnt_o are 0 immediately; after release, the next header carries seq 0.
6. Macro defined, TIMEOUT_CYC = 16, granted source never pulses done.
   -> grant_o drops 16 cycles after grant; err_o[1] = 1; pkt_cnt_o unchanged.
